list_stream_cache: RTL and testbench

- Parametrised successor to the single-list prefetch cache.
- Takes an AXI4-Stream of wide beats, each carrying FS = DBW/DW packed list elements, into a BS-line ring buffer.
- Replays the elements one per transfer to a HoP consumer over a valid/ready handshake.
- Adds configurable depth, end-of-list marking (TLAST -> O_LAST), flush, and an occupancy output.

---
 rtl/list_stream_cache.sv | 166 ++++++++++++++++
 tb/tb_list_stream_cache.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/list_stream_cache.sv
// list_stream_cache: ring buffer of BS wide stream lines, replayed one
// element per transfer to a valid/ready consumer, with end-of-list marking,
// flush and an occupancy count.
module list_stream_cache #(
    parameter int DW  = 32,
    parameter int DBW = 256,
    parameter int BS  = 4
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic [DBW-1:0]            TDATA,
    input  logic                      TVALID,
    output logic                      TREADY,
    input  logic                      TLAST,
    input  logic                      FLUSH,
    input  logic                      I_READY,
    output logic [DW-1:0]             OUT,
    output logic                      O_VALID,
    output logic                      O_LAST,
    output logic [$clog2(BS+1)-1:0]   LEVEL
);

    localparam int FS = DBW / DW;
    localparam int IW = (FS > 1) ? $clog2(FS) : 1;
    localparam int PW = $clog2(BS);
    localparam int LW = $clog2(BS + 1);

    localparam logic [IW-1:0] LAST_IDX = IW'(FS - 1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [LW-1:0] LVL_ONE  = LW'(1);
    localparam logic [LW-1:0] LVL_FULL = LW'(BS);

    // Parameter legality is checked at elaboration.
    if ((DBW % DW) != 0 || FS < 1 || (FS & (FS - 1)) != 0) begin : g_fs_check
        $error("list_stream_cache: DBW/DW must be an integer power of 2");
    end
    if (BS < 2 || (BS & (BS - 1)) != 0) begin : g_bs_check
        $error("list_stream_cache: BS must be a power of 2 and >= 2");
    end

    logic [DBW-1:0] line_data_q [BS];
    logic [DBW-1:0] line_data_d [BS];
    logic           line_last_q [BS];
    logic           line_last_d [BS];

    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [LW-1:0]  level_q, level_d;
    logic [DW-1:0]  out_q, out_d;
    logic           o_valid_q, o_valid_d;
    logic           o_last_q, o_last_d;

    logic           tready_s;
    logic           push_s;
    logic           load_s;
    logic           free_s;
    logic [DW-1:0]  elem_s;

    // Handshake qualifiers; a full buffer never accepts, even if a line frees now.
    always_comb begin
        tready_s = ~ARESET & ~FLUSH & (level_q != LVL_FULL);
        push_s   = TVALID & tready_s;
        load_s   = (~o_valid_q | I_READY) & (level_q != '0);
        free_s   = load_s & (idx_q == LAST_IDX);
        elem_s   = line_data_q[rd_ptr_q][DW*int'(idx_q) +: DW];
    end

    // Line storage write: an accepted beat lands in the line at the write pointer.
    always_comb begin
        line_data_d = line_data_q;
        line_last_d = line_last_q;
        if (push_s) begin
            line_data_d[wr_ptr_q] = TDATA;
            line_last_d[wr_ptr_q] = TLAST;
        end else begin
            line_data_d[wr_ptr_q] = line_data_q[wr_ptr_q];
            line_last_d[wr_ptr_q] = line_last_q[wr_ptr_q];
        end
    end

    // Pointer, occupancy and output-register next state; flush empties everything.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        idx_d     = idx_q;
        level_d   = level_q;
        out_d     = out_q;
        o_valid_d = o_valid_q;
        o_last_d  = o_last_q;
        if (FLUSH) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            idx_d     = '0;
            level_d   = '0;
            o_valid_d = 1'b0;
            o_last_d  = 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end

            if (load_s) begin
                out_d     = elem_s;
                o_valid_d = 1'b1;
                o_last_d  = (idx_q == LAST_IDX) & line_last_q[rd_ptr_q];
                if (idx_q == LAST_IDX) begin
                    idx_d    = '0;
                    rd_ptr_d = rd_ptr_q + PTR_ONE;
                end else begin
                    idx_d    = idx_q + IDX_ONE;
                end
            end else if (~o_valid_q | I_READY) begin
                o_valid_d = 1'b0;
                o_last_d  = 1'b0;
            end else begin
                out_d     = out_q;
                o_valid_d = o_valid_q;
                o_last_d  = o_last_q;
            end

            case ({push_s, free_s})
                2'b10:   level_d = level_q + LVL_ONE;
                2'b01:   level_d = level_q - LVL_ONE;
                default: level_d = level_q;
            endcase
        end
    end

    // Line data needs no reset: occupancy alone decides what is readable.
    always_ff @(posedge ACLK) begin
        line_data_q <= line_data_d;
        line_last_q <= line_last_d;
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            idx_q     <= '0;
            level_q   <= '0;
            out_q     <= '0;
            o_valid_q <= 1'b0;
            o_last_q  <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            idx_q     <= idx_d;
            level_q   <= level_d;
            out_q     <= out_d;
            o_valid_q <= o_valid_d;
            o_last_q  <= o_last_d;
        end
    end

    assign TREADY  = tready_s;
    assign OUT     = out_q;
    assign O_VALID = o_valid_q;
    assign O_LAST  = o_last_q;
    assign LEVEL   = level_q;

endmodule

// File: tb/tb_list_stream_cache.sv
// Scoreboard bench for list_stream_cache with DW=32, DBW=128 (FS=4), BS=2.
module tb_list_stream_cache;

    logic         clk = 1'b0;
    logic         ARESET;
    logic [127:0] TDATA;
    logic         TVALID;
    logic         TREADY;
    logic         TLAST;
    logic         FLUSH;
    logic         I_READY;
    logic [31:0]  OUT;
    logic         O_VALID;
    logic         O_LAST;
    logic [1:0]   LEVEL;

    typedef struct packed {
        logic        last;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   pop_cyc[$];
    int   cyc = 0;
    int   n_pop = 0;
    int   vectors = 0;
    int   miscompares = 0;

    list_stream_cache #(.DW(32), .DBW(128), .BS(2)) dut (
        .ACLK    (clk),
        .ARESET  (ARESET),
        .TDATA   (TDATA),
        .TVALID  (TVALID),
        .TREADY  (TREADY),
        .TLAST   (TLAST),
        .FLUSH   (FLUSH),
        .I_READY (I_READY),
        .OUT     (OUT),
        .O_VALID (O_VALID),
        .O_LAST  (O_LAST),
        .LEVEL   (LEVEL)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Offer one beat of elements base..base+3 until accepted, then record expectations.
    task automatic send_beat(input logic [31:0] base, input logic last);
        logic acc;
        int   n;
        TDATA  = {base + 32'd3, base + 32'd2, base + 32'd1, base};
        TLAST  = last;
        TVALID = 1'b1;
        acc    = 1'b0;
        n      = 0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = TREADY;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: beat %0h not accepted, expected acceptance", base);
        end else begin
            for (int i = 0; i < 4; i++) begin
                exp_q.push_back('{last: (last && i == 3), data: base + 32'(i)});
            end
        end
    endtask

    // Wait (bounded) until every expected element has been seen.
    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(name, 32'(exp_q.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Monitor: every transfer is popped from the scoreboard and compared.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (ARESET !== 1'b1 && O_VALID === 1'b1 && I_READY === 1'b1) begin
            n_pop++;
            pop_cyc.push_back(cyc);
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_out: got OUT=%0h LAST=%0b, expected no transfer", OUT, O_LAST);
            end else begin
                e = exp_q.pop_front();
                if ({O_LAST, OUT} !== {e.last, e.data}) begin
                    miscompares++;
                    $display("FAIL element: got OUT=%0h LAST=%0b, expected OUT=%0h LAST=%0b",
                             OUT, O_LAST, e.data, e.last);
                end
            end
        end
    end

    initial begin
        int mark;
        ARESET  = 1'b1;
        TVALID  = 1'b1;
        TDATA   = 128'd0;
        TLAST   = 1'b0;
        FLUSH   = 1'b0;
        I_READY = 1'b0;

        // Power-on reset held 3 cycles with TVALID high.
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_tready", 32'(TREADY), 32'd0);
            check("rst_ovalid", 32'(O_VALID), 32'd0);
            check("rst_level", 32'(LEVEL), 32'd0);
        end
        check("rst_out", OUT, 32'd0);
        check("rst_olast", 32'(O_LAST), 32'd0);
        @(posedge clk);
        #1;
        ARESET = 1'b0;
        TVALID = 1'b0;
        @(negedge clk);
        check("tready_after_rst", 32'(TREADY), 32'd1);

        // Single list: elements 1,2,3,4; first appears one edge after acceptance.
        @(posedge clk);
        #1;
        I_READY = 1'b1;
        send_beat(32'd1, 1'b1);
        TVALID = 1'b0;
        @(negedge clk);
        check("lat_ovalid_k", 32'(O_VALID), 32'd0);
        check("lat_level_k", 32'(LEVEL), 32'd1);
        @(negedge clk);
        check("lat_ovalid_k1", 32'(O_VALID), 32'd1);
        check("lat_out_k1", OUT, 32'd1);
        drain("single_drain");
        check("single_ovalid_end", 32'(O_VALID), 32'd0);
        check("single_level_end", 32'(LEVEL), 32'd0);

        // Backpressure: two beats fill the buffer, third waits for a line to free.
        I_READY = 1'b0;
        send_beat(32'h10, 1'b0);
        send_beat(32'h20, 1'b0);
        mark = n_pop;
        fork
            send_beat(32'h30, 1'b1);
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("full_level", 32'(LEVEL), 32'd2);
                    check("full_tready", 32'(TREADY), 32'd0);
                    check("stall_ovalid", 32'(O_VALID), 32'd1);
                    check("stall_out", OUT, 32'h10);
                end
                @(posedge clk);
                #1;
                I_READY = 1'b1;
            end
        join
        check("third_accept_after_free", 32'(n_pop - mark), 32'd4);
        TVALID = 1'b0;
        drain("bp_drain");
        check("bp_level_end", 32'(LEVEL), 32'd0);

        // Continuous stream: 6 beats, lists end at beats 3 and 6, no bubbles.
        pop_cyc.delete();
        for (int b = 1; b <= 6; b++) begin
            send_beat(32'(b * 32'h100), (b == 3 || b == 6));
        end
        TVALID = 1'b0;
        drain("stream_drain");
        check("stream_count", 32'(pop_cyc.size()), 32'd24);
        if (pop_cyc.size() == 24) begin
            check("stream_gapfree", 32'(pop_cyc[23] - pop_cyc[0]), 32'd23);
        end else begin
            check("stream_gapfree", 32'(pop_cyc.size()), 32'd24);
        end

        // Flush after 2 of 4 elements consumed with one further line buffered.
        I_READY = 1'b0;
        send_beat(32'h40, 1'b0);
        send_beat(32'h50, 1'b1);
        TVALID  = 1'b0;
        I_READY = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        I_READY = 1'b0;
        @(negedge clk);
        check("preflush_out", OUT, 32'h42);
        check("preflush_level", 32'(LEVEL), 32'd2);
        @(posedge clk);
        #1;
        exp_q.delete();
        FLUSH = 1'b1;
        @(negedge clk);
        check("flush_tready", 32'(TREADY), 32'd0);
        @(posedge clk);
        #1;
        FLUSH = 1'b0;
        @(negedge clk);
        check("flush_ovalid", 32'(O_VALID), 32'd0);
        check("flush_level", 32'(LEVEL), 32'd0);
        @(posedge clk);
        #1;
        I_READY = 1'b1;
        send_beat(32'h60, 1'b1);
        TVALID = 1'b0;
        drain("postflush_drain");

        // Reset mid-operation with a full buffer and a presented element.
        I_READY = 1'b0;
        send_beat(32'h70, 1'b0);
        send_beat(32'h80, 1'b1);
        TVALID = 1'b0;
        @(negedge clk);
        check("prerst_level", 32'(LEVEL), 32'd2);
        check("prerst_ovalid", 32'(O_VALID), 32'd1);
        @(posedge clk);
        #1;
        ARESET = 1'b1;
        exp_q.delete();
        @(posedge clk);
        repeat (2) begin
            @(negedge clk);
            check("midrst_tready", 32'(TREADY), 32'd0);
            check("midrst_ovalid", 32'(O_VALID), 32'd0);
            check("midrst_level", 32'(LEVEL), 32'd0);
            check("midrst_out", OUT, 32'd0);
            check("midrst_olast", 32'(O_LAST), 32'd0);
        end
        @(posedge clk);
        #1;
        ARESET  = 1'b0;
        I_READY = 1'b1;
        repeat (6) @(negedge clk);
        check("postrst_ovalid", 32'(O_VALID), 32'd0);
        check("postrst_level", 32'(LEVEL), 32'd0);
        @(posedge clk);
        #1;
        send_beat(32'h90, 1'b1);
        TVALID = 1'b0;
        drain("postrst_drain");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
